fmap_streamer: RTL and testbench

- Producer side of the 5x5 sliding-window line buffer: reads a stored feature map from single-port RAM in raster order and drives the window's pixel input and shift enable.
- Tracks which shifts complete a valid 5-row tap column and flags them with row/column indices for the downstream conv array.
- Supports two frame geometries chosen by `state`: 0 gives 28x28 (W=28), 1 gives 12x12 (W=12).
- Sits between the feature-map RAM and the window buffer.

---
 rtl/fmap_streamer_if.sv | 56 +++++
 rtl/fmap_streamer.sv | 231 +++++++++++++++++++++++
 tb/tb_fmap_streamer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_streamer_if.sv
// fmap_streamer_if: frame-control, feature-map RAM and window-feed signals of the
// feature-map streamer. The streamer connects through the master modport; the
// surrounding fabric (RAM, window buffer, controller) uses the slave modport.
interface fmap_streamer_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
);
  // Frame control
  logic                 go;
  logic                 state;
  logic                 stall;
  logic                 busy;
  logic                 done;
  // Feature-map RAM read port
  logic                 ram_rd_en;
  logic [AW-1:0]        ram_addr;
  logic signed [DW-1:0] ram_dout;
  // Window buffer feed and tap tagging
  logic signed [DW-1:0] din;
  logic                 shift;
  logic                 win_valid;
  logic [4:0]           win_row;
  logic [4:0]           win_col;

  modport master (
    input  go,
    input  state,
    input  stall,
    input  ram_dout,
    output ram_rd_en,
    output ram_addr,
    output din,
    output shift,
    output win_valid,
    output win_row,
    output win_col,
    output busy,
    output done
  );

  modport slave (
    output go,
    output state,
    output stall,
    output ram_dout,
    input  ram_rd_en,
    input  ram_addr,
    input  din,
    input  shift,
    input  win_valid,
    input  win_row,
    input  win_col,
    input  busy,
    input  done
  );
endinterface

// File: rtl/fmap_streamer.sv
// fmap_streamer: reads a stored feature map (28x28 or 12x12) from single-port RAM in
// raster order and feeds it, one pixel per shift, into the 5x5 sliding-window line
// buffer. Each shift is tagged with the row/column of the window's bottom tap and
// whether the taps form a complete 5-row column.
//
// Optional build macro FMAP_STREAMER_FLUSH_EN: after the last pixel, W-1 zero pixels
// are shifted in so the final row's trailing columns also get tagged.
//
// Data path: RAM (1-cycle latency) -> optional 1-entry skid -> output register.
// The output register drives din; shift = output valid and not stalled, so a stall
// suppresses the shift in the same cycle and the pixel waits in place.
module fmap_streamer #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 10,
  parameter int unsigned BASE0 = 0,
  parameter int unsigned BASE1 = 784
) (
  input  logic            clk,
  input  logic            rst,
  fmap_streamer_if.master bus
);

  // Counters are sized for the largest frame plus flush shifts (784 + 27).
  localparam int unsigned CW = 10;
  localparam int unsigned W0 = 28;
  localparam int unsigned W1 = 12;

  localparam logic [CW-1:0] W0C = CW'(W0);
  localparam logic [CW-1:0] W1C = CW'(W1);
  localparam logic [CW-1:0] N0C = CW'(W0 * W0);
  localparam logic [CW-1:0] N1C = CW'(W1 * W1);
  localparam logic [AW-1:0] B0C = AW'(BASE0);
  localparam logic [AW-1:0] B1C = AW'(BASE1);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
`ifdef FMAP_STREAMER_FLUSH_EN
    StFlush,
`endif
    StFin
  } st_e;

  st_e                  st_q;
  logic [CW-1:0]        w_q;
  logic [CW-1:0]        n_q;
  logic [AW-1:0]        base_q;
  logic [CW-1:0]        rd_cnt_q;
  logic [CW-1:0]        sh_cnt_q;
  logic [4:0]           qr_q;
  logic [4:0]           qc_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef FMAP_STREAMER_FLUSH_EN
  logic [CW-1:0]        fl_cnt_q;
`endif

  // Read pipeline state
  logic                 pend_q;       // a read (or flush zero) returns this cycle
  logic                 pend_zero_q;  // the returning entry is a flush zero, not RAM data
  logic                 out_v_q;
  logic signed [DW-1:0] out_d_q;
  logic                 skid_v_q;
  logic signed [DW-1:0] skid_d_q;

  logic                 consume;
  logic [1:0]           occ;
  logic                 room;
  logic                 rd_issue;
  logic                 fl_issue;
  logic signed [DW-1:0] src_d;
  logic [CW-1:0]        wm1;
  logic                 q_on;
  logic                 tag_hit;

  // Issue control, returning-data select and window tag decode.
  always_comb begin
    wm1     = w_q - CW'(1);
    consume = out_v_q & ~bus.stall;
    // Entries held after this edge, before any new issue lands. An issue is allowed
    // only if its data will still find a free register (output or skid).
    occ     = 2'(out_v_q) + 2'(skid_v_q) + 2'(pend_q) - 2'(consume);
    room    = (occ <= 2'd1);
    rd_issue = (st_q == StRun) && !bus.stall && room;
    fl_issue = 1'b0;
`ifdef FMAP_STREAMER_FLUSH_EN
    fl_issue = (st_q == StFlush) && !bus.stall && room && (fl_cnt_q < wm1);
`endif
    src_d   = pend_zero_q ? '0 : bus.ram_dout;
    // q = p - (W-1) is non-negative once p reaches W-1; qr/qc track q's row/col.
    q_on    = (sh_cnt_q >= wm1);
    tag_hit = q_on && (qr_q >= 5'd4) && (sh_cnt_q < n_q + wm1);
  end

  assign bus.ram_rd_en = rd_issue;
  assign bus.ram_addr  = rd_issue ? base_q + AW'(rd_cnt_q) : '0;
  assign bus.din       = out_d_q;
  assign bus.shift     = consume;
  assign bus.win_valid = consume & tag_hit;
  assign bus.win_row   = consume ? qr_q : 5'd0;
  assign bus.win_col   = consume ? qc_q : 5'd0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Frame sequencing: geometry latch, read/shift counters and window position.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StIdle;
      w_q      <= '0;
      n_q      <= '0;
      base_q   <= '0;
      rd_cnt_q <= '0;
      sh_cnt_q <= '0;
      qr_q     <= '0;
      qc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FMAP_STREAMER_FLUSH_EN
      fl_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;

      if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + CW'(1);
      end

      if (consume) begin
        sh_cnt_q <= sh_cnt_q + CW'(1);
        if (q_on) begin
          if ({5'd0, qc_q} == wm1) begin
            qc_q <= '0;
            qr_q <= qr_q + 5'd1;
          end else begin
            qc_q <= qc_q + 5'd1;
          end
        end
      end

      case (st_q)
        StIdle: begin
          if (bus.go) begin
            w_q      <= bus.state ? W1C : W0C;
            n_q      <= bus.state ? N1C : N0C;
            base_q   <= bus.state ? B1C : B0C;
            rd_cnt_q <= '0;
            sh_cnt_q <= '0;
            qr_q     <= '0;
            qc_q     <= '0;
`ifdef FMAP_STREAMER_FLUSH_EN
            fl_cnt_q <= '0;
`endif
            busy_q   <= 1'b1;
            st_q     <= StRun;
          end
        end
        StRun: begin
          if (rd_issue && (rd_cnt_q == n_q - CW'(1))) begin
            st_q <= StDrain;
          end
        end
        StDrain: begin
          if (sh_cnt_q == n_q) begin
`ifdef FMAP_STREAMER_FLUSH_EN
            st_q   <= StFlush;
`else
            st_q   <= StFin;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end
        end
`ifdef FMAP_STREAMER_FLUSH_EN
        StFlush: begin
          if (fl_issue) begin
            fl_cnt_q <= fl_cnt_q + CW'(1);
          end
          if (sh_cnt_q == n_q + wm1) begin
            st_q   <= StFin;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
`endif
        StFin: begin
          st_q <= StIdle;
        end
        default: begin
          st_q <= StIdle;
        end
      endcase
    end
  end

  // Read pipeline: returning data goes to the output register when it is free,
  // otherwise into the skid slot; the skid always drains ahead of newer data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_zero_q <= 1'b0;
      out_v_q     <= 1'b0;
      out_d_q     <= '0;
      skid_v_q    <= 1'b0;
      skid_d_q    <= '0;
    end else begin
      pend_q      <= rd_issue | fl_issue;
      pend_zero_q <= fl_issue;
      if (!out_v_q || consume) begin
        if (skid_v_q) begin
          out_d_q <= skid_d_q;
          out_v_q <= 1'b1;
          if (pend_q) begin
            skid_d_q <= src_d;
          end else begin
            skid_v_q <= 1'b0;
          end
        end else if (pend_q) begin
          out_d_q <= src_d;
          out_v_q <= 1'b1;
        end else begin
          out_v_q <= 1'b0;
        end
      end else if (pend_q) begin
        skid_d_q <= src_d;
        skid_v_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fmap_streamer.sv
// tb_fmap_streamer: scoreboard bench for fmap_streamer. Each frame start pushes the
// expected read addresses and per-shift records (pixel, tag) to queues; a negedge
// monitor pops and compares them as the DUT issues reads and shifts.
module tb_fmap_streamer;

  localparam int DW = 16;
  localparam int AW = 10;

  typedef struct {
    logic signed [15:0] d;
    bit                 v;
    int                 r;
    int                 c;
  } sh_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fmap_streamer_if #(.DW(DW), .AW(AW)) bus ();

  fmap_streamer #(
    .DW   (DW),
    .AW   (AW),
    .BASE0(0),
    .BASE1(784)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int  addr_q[$];
  sh_t sh_q[$];
  int  exp_total, exp_vcnt, cur_w;
  int  frame_sh, frame_v, first_rd_cyc, first_sh_cyc, first_v_p, last_v_r, last_v_c;
  sh_t e_mon;
  int  a_mon;

  function automatic logic signed [15:0] pix(input int a);
    int v;
    v = a * 37 + 5;
    return v[15:0];
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // RAM model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_dout <= pix(int'(bus.ram_addr));
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare reads and shifts against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (addr_q.size() == 0) begin
          check_eq("rd_unexpected", int'(bus.ram_addr), -1);
        end else begin
          a_mon = addr_q.pop_front();
          check_eq("rd_addr", int'(bus.ram_addr), a_mon);
        end
      end
      if (bus.stall) check_eq("shift_in_stall", int'(bus.shift), 0);
      if (bus.shift) begin
        if (first_sh_cyc < 0) first_sh_cyc = cyc;
        if (sh_q.size() == 0) begin
          check_eq("shift_unexpected", int'(bus.shift), 0);
        end else begin
          e_mon = sh_q.pop_front();
          check_eq("din", int'($signed(bus.din)), int'(e_mon.d));
          check_eq("win_valid", int'(bus.win_valid), int'(e_mon.v));
          if (e_mon.v) begin
            check_eq("win_row", int'(bus.win_row), e_mon.r);
            check_eq("win_col", int'(bus.win_col), e_mon.c);
          end
        end
        if (bus.win_valid) begin
          if (first_v_p < 0) first_v_p = frame_sh;
          last_v_r = int'(bus.win_row);
          last_v_c = int'(bus.win_col);
          frame_v++;
        end
        frame_sh++;
      end else begin
        check_eq("tags_no_shift", int'({bus.win_valid, bus.win_row, bus.win_col}), 0);
      end
    end
  end

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_rd_en"}, int'(bus.ram_rd_en), 0);
    check_eq({pfx, "_addr"}, int'(bus.ram_addr), 0);
    check_eq({pfx, "_din"}, int'(bus.din), 0);
    check_eq({pfx, "_shift"}, int'(bus.shift), 0);
    check_eq({pfx, "_win_valid"}, int'(bus.win_valid), 0);
    check_eq({pfx, "_win_row"}, int'(bus.win_row), 0);
    check_eq({pfx, "_win_col"}, int'(bus.win_col), 0);
    check_eq({pfx, "_busy"}, int'(bus.busy), 0);
    check_eq({pfx, "_done"}, int'(bus.done), 0);
  endtask

  task automatic start_frame(input bit st);
    int  w, n, base, total, q;
    sh_t e;
    w     = st ? 12 : 28;
    n     = w * w;
    base  = st ? 784 : 0;
    total = n;
`ifdef FMAP_STREAMER_FLUSH_EN
    total = n + w - 1;
`endif
    addr_q.delete();
    sh_q.delete();
    exp_vcnt = 0;
    for (int i = 0; i < n; i++) addr_q.push_back(base + i);
    for (int p = 0; p < total; p++) begin
      q   = p - (w - 1);
      e.d = (p < n) ? pix(base + p) : 16'sd0;
      e.v = (q >= 4 * w) && (q < n);
      e.r = e.v ? q / w : 0;
      e.c = e.v ? q % w : 0;
      if (e.v) exp_vcnt++;
      sh_q.push_back(e);
    end
    exp_total    = total;
    cur_w        = w;
    frame_sh     = 0;
    frame_v      = 0;
    first_rd_cyc = -1;
    first_sh_cyc = -1;
    first_v_p    = -1;
    last_v_r     = -1;
    last_v_c     = -1;
    @(posedge clk); #1;
    bus.go    = 1'b1;
    bus.state = st;
    @(posedge clk); #1;
    bus.go = 1'b0;
    check_eq("busy_rise", int'(bus.busy), 1);
  endtask

  // mode 0: plain, 1: periodic stall, 2: go pulses and state toggles while busy
  task automatic run_frame(input bit st, input int mode, input int budget);
    bit got;
    got = 1'b0;
    start_frame(st);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (mode == 1) bus.stall = ((k % 10) < 3);
      if (mode == 2) begin
        bus.go = (k == 40) || (k == 90);
        if (k == 40 || k == 60) bus.state = ~bus.state;
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    bus.stall = 1'b0;
    bus.go    = 1'b0;
    bus.state = st;
    if (!got) begin
      check_eq("done_timeout", 0, 1);
    end else begin
      check_eq("busy_at_done", int'(bus.busy), 0);
      check_eq("shift_count", frame_sh, exp_total);
      check_eq("valid_count", frame_v, exp_vcnt);
      check_eq("addr_left", addr_q.size(), 0);
      check_eq("shift_left", sh_q.size(), 0);
      if (mode != 1) check_eq("first_shift_lat", first_sh_cyc - first_rd_cyc, 2);
      check_eq("first_valid_p", first_v_p, 5 * cur_w - 1);
      if (st) begin
        check_eq("last_valid_row", last_v_r, 11);
`ifdef FMAP_STREAMER_FLUSH_EN
        check_eq("last_valid_col", last_v_c, 11);
`else
        check_eq("last_valid_col", last_v_c, 0);
`endif
      end
      @(posedge clk); #1;
      check_eq("done_pulse", int'(bus.done), 0);
    end
  endtask

  initial begin
    bit hit;
    bus.go    = 1'b0;
    bus.state = 1'b0;
    bus.stall = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    run_frame(1'b0, 0, 3000);
    run_frame(1'b1, 0, 1000);
    run_frame(1'b1, 1, 2000);
    run_frame(1'b1, 2, 1000);

    // Reset in the middle of a 28x28 frame
    start_frame(1'b0);
    hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (frame_sh >= 300) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check_eq("wait300_timeout", 0, 1);
    rst = 1'b1;
    addr_q.delete();
    sh_q.delete();
    @(posedge clk); #1;
    check_zero_outputs("midrst");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("post_rst_shift", int'(bus.shift), 0);
      check_eq("post_rst_rd_en", int'(bus.ram_rd_en), 0);
    end
    run_frame(1'b0, 0, 3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
